// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One quotient/product bit per cycle over 32 cycles on operand magnitudes,
// followed by a single sign-correction cycle and a one-cycle done pulse.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; mthi/mtlo writes accepted when start=0
// RUN   | 32 iterations of shift-add (mul) or restoring shift-subtract (div)
// FIX   | sign correction; HI/LO written at the exit edge
// DONE  | done pulse for one cycle; mthi/mtlo accepted when start=0
module mdu_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] b_q;
  logic [63:0] acc_q;
  logic        is_div_q;
  logic        neg_q_q;
  logic        neg_r_q;

  // Operand magnitudes and sign flags captured with start.
  logic        sgn_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // One iteration step and the sign-corrected results.
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] acc_d;
  logic [63:0] prod_neg;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        wr_ok;

  // Start-time operand conditioning: signed ops iterate on absolute values.
  always_comb begin
    sgn_op = op[0];
    a_mag  = (sgn_op && i1[31]) ? (~i1 + 32'd1) : i1;
    b_mag  = (sgn_op && i2[31]) ? (~i2 + 32'd1) : i2;
  end

  // Iteration datapath and FIX-cycle sign correction.
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_step = {mul_sum, acc_q[31:1]};
    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, b_q};
    div_step  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    acc_d     = is_div_q ? div_step : mul_step;

    prod_neg = ~acc_q + 64'd1;
    hi_d     = 32'd0;
    lo_d     = 32'd0;
    if (is_div_q) begin
      // A zero divisor leaves the dividend magnitude as remainder; restoring
      // its sign returns i1 unchanged, and the quotient is forced to all ones.
      if (b_q == 32'd0)
        lo_d = 32'hFFFF_FFFF;
      else
        lo_d = neg_q_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      hi_d = neg_r_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end else begin
      {hi_d, lo_d} = neg_q_q ? prod_neg : acc_q;
    end

    wr_ok = ((state_q == IDLE) || (state_q == DONE)) && !start;
  end

  // Sequencer, iteration registers and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            cnt_q    <= 5'd31;
            busy_q   <= 1'b1;
            acc_q    <= {32'd0, a_mag};
            b_q      <= b_mag;
            is_div_q <= op[1];
            neg_q_q  <= sgn_op && (i1[31] ^ i2[31]);
            neg_r_q  <= sgn_op && i1[31];
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_q == 5'd0)
            state_q <= FIX;
          else
            cnt_q <= cnt_q - 5'd1;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: scoreboard of expected {HI,LO} pushed at issue and
// popped on done, plus latency/busy-length, hold, mthi/mtlo and reset checks.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] i1;
  logic [31:0] i2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_chk;
  int          n_fail;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .i1    (i1),
    .i2    (i2),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference {HI,LO} for one operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0]        r;
    sa64 = $signed({{32{a[31]}}, a});
    sb64 = $signed({{32{b[31]}}, b});
    sa   = $signed(a);
    sb   = $signed(b);
    r    = 64'd0;
    case (o)
      2'b00: r = {32'd0, a} * {32'd0, b};
      2'b01: r = sa64 * sb64;
      2'b10: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0)
          r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = {32'd0, 32'h8000_0000};
        else
          r = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return r;
  endfunction

  // Scoreboard consumer: every done pulse retires one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
        chk("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
        hi_m = e[63:32];
        lo_m = e[31:0];
      end
    end
  end

  // Issue one op; inj>0 injects a second start + mtlo at that cycle,
  // rst_at>0 pulses reset at that cycle to abort the op.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int rst_at);
    int n;
    int nb;
    logic hold_bad;
    @(negedge clk);
    start = 1'b1; op = o; i1 = a; i2 = b;
    if (rst_at == 0) sb_q.push_back(model(o, a, b));
    @(posedge clk);
    n = 1; nb = 0; hold_bad = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      start = 1'b0; mtlo = 1'b0;
      if (n == inj) begin
        start = 1'b1; op = 2'b00; i1 = 32'd9; i2 = 32'd9;
        mtlo = 1'b1; wdata = 32'hAA;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        #2 rst = 1'b0;
        return;
      end
      if (busy) begin
        nb++;
        if (hi !== hi_m || lo !== lo_m) hold_bad = 1'b1;
      end
      if (done) break;
      @(posedge clk);
      n++;
    end
    chk("done_latency", 64'(n), 64'd34);
    chk("busy_cycles", 64'(nb), 64'd33);
    chk("hold_hilo", {63'd0, hold_bad}, 64'd0);
    chk("done_busy_excl", {63'd0, busy & done}, 64'd0);
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    chk("done_pulse", {63'd0, done}, 64'd0);
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
    @(negedge clk);
    mthi = wh; mtlo = wl; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) hi_m = d;
    if (wl) lo_m = d;
    chk("mt_hi", {32'd0, hi}, {32'd0, hi_m});
    chk("mt_lo", {32'd0, lo}, {32'd0, lo_m});
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    hi_m = 32'd0; lo_m = 32'd0;
    rst = 1'b1; start = 1'b0; op = 2'b00; i1 = 32'd0; i2 = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);

    run_op(2'b00, 32'd5, 32'd7, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b10, 32'h1234_5678, 32'd0, 0, 0);
    run_op(2'b11, 32'hF000_0000, 32'd0, 0, 0);
    // Second start and mtlo during busy must both be ignored.
    run_op(2'b00, 32'd5, 32'd7, 10, 0);
    chk("ignored_lo", {32'd0, lo}, 64'h23);
    mt_write(1'b0, 1'b1, 32'hAA);
    mt_write(1'b1, 1'b1, 32'h5555_1234);
    // Reset mid-operation aborts; the next op runs normally.
    run_op(2'b10, 32'd100, 32'd7, 0, 15);
    run_op(2'b10, 32'd100, 32'd7, 0, 0);
    chk("divu_lo", {32'd0, lo}, 64'h0E);
    chk("divu_hi", {32'd0, hi}, 64'h02);

    for (int k = 0; k < 8; k++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = (k == 3) ? 32'd0 : $urandom();
      if (k == 5) rb = 32'hFFFF_FFFF;
      run_op(ro, ra, rb, 0, 0);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
